// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1/8E1 UART receiver; optional parity via macro UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic             rx_meta_q;
  logic             rx_sync_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       char_q, char_d;
  logic             char_valid_q, char_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             frame_ok;

`ifdef UART_RX_PARITY_EN
  logic             parity_ok_q, parity_ok_d;

  // Parity verdict captured in PARITY and consumed at the stop sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_ok_q <= 1'b0;
    end else begin
      parity_ok_q <= parity_ok_d;
    end
  end

  assign frame_ok = parity_ok_q;
`else
  assign frame_ok = 1'b1;
`endif

  // Two-flop synchronizer; flops reset to the idle-high line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      char_q        <= 8'h00;
      char_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      char_q        <= char_d;
      char_valid_q  <= char_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic: half-bit wait on the start bit, then full-bit sampling
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    char_d        = char_q;
    char_valid_d  = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_d   = parity_ok_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            // Start bit did not survive to mid-bit: a glitch, drop it
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d       = '0;
          // Even parity: data bits plus parity bit must XOR to zero
          parity_ok_d = ~(^shift_q ^ rx_sync_q);
          state_d     = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q && frame_ok) begin
            char_d       = shift_q;
            char_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else if (rx_sync_q) begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            // Low stop bit: line may be in break, wait for it to recover
            frame_error_d = 1'b1;
            state_d       = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ascii_char  = char_q;
  assign char_valid  = char_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Pin fall to strobe: 2 synchronizer cycles, half bit, 8 data (+parity) + stop, 1 register
  localparam int PULSE_LAT = 3 + HALF + (9 + PAR) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .ascii_char  (ascii_char),
    .char_valid  (char_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observed strobes
  int         obs_kind[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         both_high = 0;
  int         stray_chg = 0;
  logic [7:0] prev_char = 8'h00;

  always @(negedge clk) begin
    if (char_valid && frame_error) both_high++;
    if (char_valid) begin
      obs_kind.push_back(0); obs_data.push_back(ascii_char); obs_cyc.push_back(cyc);
    end
    if (frame_error) begin
      obs_kind.push_back(1); obs_data.push_back(8'h00); obs_cyc.push_back(cyc);
    end
    if (!rst) prev_char = 8'h00;
    else begin
      if (ascii_char !== prev_char && !char_valid) stray_chg++;
      prev_char = ascii_char;
    end
  end

  // Reference model: expected strobes and the last good byte
  int         exp_kind[$];
  logic [7:0] exp_data[$];
  int         exp_cyc[$];
  logic [7:0] last_good = 8'h00;

  task automatic drive_bits(input logic v, input int nbits);
    rx = v;
    repeat (nbits * CPB) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic bad_par);
    int   t0;
    logic good;
    t0   = cyc;
    good = stop_v && !(PAR == 1 && bad_par);
    exp_kind.push_back(good ? 0 : 1);
    exp_data.push_back(good ? b : 8'h00);
    exp_cyc.push_back(t0 + PULSE_LAT);
    if (good) last_good = b;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    if (PAR == 1) drive_bits((^b) ^ bad_par, 1);
    drive_bits(stop_v, 1);
  endtask

  logic [7:0] stream [7] = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h2B, 8'h58, 8'h00};
  logic [7:0] v55;

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("rst_ascii", ascii_char, 8'h00);
    check("rst_valid", char_valid, 0);
    check("rst_ferr",  frame_error, 0);
    check("rst_busy",  busy, 0);
    rst = 1'b1;
    drive_bits(1'b1, 10);
    check("idle_no_strobe", obs_kind.size(), 0);

    // Single byte
    send_frame(8'h31, 1'b1, 1'b0);
    drive_bits(1'b1, 1);
    check("single_ascii", ascii_char, 8'h31);
    check("single_busy", busy, 0);

    // Bad stop bit followed by a break
    send_frame(8'h41, 1'b0, 1'b0);
    drive_bits(1'b0, 3);
    drive_bits(1'b1, 2);
    check("break_ascii_kept", ascii_char, 8'h31);
    check("break_busy", busy, 0);
    send_frame(8'h42, 1'b1, 1'b0);
    drive_bits(1'b1, 1);
    check("after_break_ascii", ascii_char, 8'h42);

    // Back-to-back stream
    foreach (stream[i]) begin
      send_frame(stream[i], 1'b1, 1'b0);
      check($sformatf("stream_%0d", i), ascii_char, stream[i]);
    end
    drive_bits(1'b1, 1);

    // Start-bit glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (HALF + 4) begin @(posedge clk); #1; end
    check("glitch_busy", busy, 0);
    drive_bits(1'b1, 1);

    // Reset during data bit 4 of 0x55
    v55 = 8'h55;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bits(v55[i], 1);
    rx = v55[4];
    repeat (HALF) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ascii", ascii_char, 8'h00);
    check("mid_rst_valid", char_valid, 0);
    check("mid_rst_ferr",  frame_error, 0);
    check("mid_rst_busy",  busy, 0);
    last_good = 8'h00;
    repeat (3) begin @(posedge clk); end
    #1;
    rst = 1'b1;
    drive_bits(1'b1, 2);
    send_frame(8'h2A, 1'b1, 1'b0);
    drive_bits(1'b1, 1);
    check("post_rst_ascii", ascii_char, 8'h2A);
    if (PAR == 1) begin
      send_frame(8'h11, 1'b1, 1'b1);
      drive_bits(1'b1, 1);
      check("bad_par_ascii", ascii_char, 8'h2A);
    end

    // Randomized frames with occasional stop/parity errors and idle gaps
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      logic       sv;
      logic       bp;
      b  = 8'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      bp = (PAR == 1) && ($urandom_range(0, 4) == 0);
      send_frame(b, sv, bp);
      check($sformatf("rand_ascii_%0d", k), ascii_char, last_good);
      if (!sv) begin
        drive_bits(1'b0, $urandom_range(0, 2));
        drive_bits(1'b1, 1);
      end else begin
        drive_bits(1'b1, $urandom_range(0, 1));
      end
    end
    drive_bits(1'b1, 2);

    // Strobe sequence against the model
    check("event_count", obs_kind.size(), exp_kind.size());
    for (int i = 0; i < obs_kind.size() && i < exp_kind.size(); i++) begin
      int d;
      d = obs_cyc[i] - exp_cyc[i];
      check($sformatf("evt%0d_kind", i), obs_kind[i], exp_kind[i]);
      check($sformatf("evt%0d_data", i), obs_data[i], exp_data[i]);
      check($sformatf("evt%0d_time", i), (d >= -1 && d <= 1), 1);
    end
    check("both_high", both_high, 0);
    check("ascii_stray_change", stray_chg, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
